// File: rtl/rast_pkg.sv
// Shared types and width helpers for the rasterizer
// barycentric normalisation path.
package rast_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    SCALE,
    OUT
  } state_t;

  localparam int MUL_CYCLES   = 6;
  localparam int SCALE_CYCLES = 3;

  function automatic int inv_width(int xw, int yw, int frac);
    return ((xw > yw) ? xw : yw) + frac - 1;
  endfunction

  // Two diff products plus one bit of growth for their difference.
  function automatic int edge_width(int xw, int yw);
    return (xw + 1) + (yw + 1) + 1;
  endfunction

  function automatic int scale_width(int xw, int yw, int frac);
    return edge_width(xw, yw) + inv_width(xw, yw, frac) + 1;
  endfunction

endpackage

// File: rtl/signed_mul_reg.sv
// Registered signed multiplier, one cycle of latency,
// full-precision product.
module signed_mul_reg #(
  parameter int AW = 18,
  parameter int BW = 18
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  output logic signed [AW+BW-1:0] p
);

  localparam int PW = AW + BW;

  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] b_x;

  assign a_x = PW'(a);
  assign b_x = PW'(b);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) p <= '0;
    else           p <= a_x * b_x;
  end

endmodule

// File: rtl/bary_normalize.sv
// Edge-function evaluation and iarea scaling of pixel queries
// into normalised barycentric weights, one shared multiplier.
module bary_normalize
  import rast_pkg::*;
#(
  parameter int XWIDTH    = 16,
  parameter int YWIDTH    = 16,
  parameter int FRAC      = 14,
  parameter int LWIDTH    = 16,
  parameter int INV_WIDTH = inv_width(XWIDTH, YWIDTH, FRAC)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  setup_valid_in,
  input  logic                  setup_done_in,
  input  logic [3*XWIDTH-1:0]   vx_in,
  input  logic [3*YWIDTH-1:0]   vy_in,
  input  logic [INV_WIDTH-1:0]  iarea_in,
  input  logic                  pix_valid_in,
  output logic                  pix_ready_out,
  input  logic [XWIDTH-1:0]     px_in,
  input  logic [YWIDTH-1:0]     py_in,
  output logic                  valid_out,
  output logic [3*LWIDTH-1:0]   lambda_out,
  output logic                  inside_out
);

  localparam int DXW   = XWIDTH + 1;
  localparam int DYW   = YWIDTH + 1;
  localparam int EW    = edge_width(XWIDTH, YWIDTH);
  localparam int BW    = INV_WIDTH + 1;
  localparam int SW    = scale_width(XWIDTH, YWIDTH, FRAC);
  localparam int SHIFT = 3 * FRAC;

  localparam logic signed [SW-1:0] LMAX = SW'((2 ** (LWIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] LMIN = ~LMAX;

  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;

  logic signed [XWIDTH-1:0] vx_r [3];
  logic signed [YWIDTH-1:0] vy_r [3];
  logic signed [XWIDTH-1:0] px_r;
  logic signed [YWIDTH-1:0] py_r;
  logic [INV_WIDTH-1:0]     iarea_r;
  logic                     degen;

  logic signed [DXW-1:0] dx [3];
  logic signed [DYW-1:0] dy [3];
  logic signed [EW-1:0]  e_acc [3];
  logic signed [LWIDTH-1:0] lam_t [2];
  logic [1:0] nn_t, np_t;

  logic [1:0] xi, yi;
  logic signed [EW-1:0] mul_a;
  logic signed [BW-1:0] mul_b;
  logic signed [SW-1:0] prod;
  logic signed [SW-1:0] shifted;
  logic signed [LWIDTH-1:0] sat_v;
  logic nn, np;

  logic setup_take, pix_acc, acc_en;
  logic [2:0] acc_k;

  function automatic logic signed [LWIDTH-1:0] sat(
    input logic signed [SW-1:0] v
  );
    if (v > LMAX)      return LMAX[LWIDTH-1:0];
    else if (v < LMIN) return LMIN[LWIDTH-1:0];
    else               return v[LWIDTH-1:0];
  endfunction

  assign pix_ready_out = (state == IDLE) & ~setup_done_in;
  assign pix_acc       = pix_ready_out & pix_valid_in;
  assign setup_take    = (state == IDLE) & setup_done_in;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 3'd1;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (pix_acc) state_nx = MUL;
      end
      MUL: begin
        if (cnt == 3'(MUL_CYCLES - 1)) begin
          state_nx = SCALE;
          cnt_nx   = '0;
        end
      end
      SCALE: begin
        if (cnt == 3'(SCALE_CYCLES - 1)) begin
          state_nx = OUT;
          cnt_nx   = '0;
        end
      end
      OUT: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      dx[i] = DXW'(vx_r[i]) - DXW'(px_r);
      dy[i] = DYW'(vy_r[i]) - DYW'(py_r);
    end
  end

  // Edge j pairs vertices j+1 and j+2; even k is the left product.
  always_comb begin
    xi = 2'd0;
    yi = 2'd0;
    case (cnt)
      3'd0: begin xi = 2'd1; yi = 2'd2; end
      3'd1: begin xi = 2'd2; yi = 2'd1; end
      3'd2: begin xi = 2'd2; yi = 2'd0; end
      3'd3: begin xi = 2'd0; yi = 2'd2; end
      3'd4: begin xi = 2'd0; yi = 2'd1; end
      3'd5: begin xi = 2'd1; yi = 2'd0; end
      default: ;
    endcase
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (1'b1)
      state == MUL: begin
        mul_a = EW'(dx[xi]);
        mul_b = BW'(dy[yi]);
      end
      state == SCALE: begin
        mul_a = e_acc[cnt[1:0]];
        mul_b = {1'b0, iarea_r};
      end
      default: ;
    endcase
  end

  // Product k lands one cycle after issue; k=5 lands in SCALE 0.
  always_comb begin
    acc_en = ((state == MUL) && (cnt != 3'd0)) ||
             ((state == SCALE) && (cnt == 3'd0));
    acc_k  = (state == MUL) ? (cnt - 3'd1) : 3'd5;
  end

  assign shifted = prod >>> SHIFT;
  assign sat_v   = sat(shifted);
  assign nn      = ~shifted[SW-1];
  assign np      = shifted[SW-1] | ~|shifted;

  signed_mul_reg #(
    .AW(EW),
    .BW(BW)
  ) u_mul (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .a        (mul_a),
    .b        (mul_b),
    .p        (prod)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      cnt        <= '0;
      degen      <= 1'b1;
      vx_r       <= '{default: '0};
      vy_r       <= '{default: '0};
      px_r       <= '0;
      py_r       <= '0;
      iarea_r    <= '0;
      e_acc      <= '{default: '0};
      lam_t      <= '{default: '0};
      nn_t       <= '0;
      np_t       <= '0;
      valid_out  <= 1'b0;
      lambda_out <= '0;
      inside_out <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      valid_out <= 1'b0;
      if (setup_take) begin
        for (int i = 0; i < 3; i++) begin
          vx_r[i] <= vx_in[i*XWIDTH +: XWIDTH];
          vy_r[i] <= vy_in[i*YWIDTH +: YWIDTH];
        end
        iarea_r <= iarea_in;
        degen   <= ~setup_valid_in;
      end
      if (pix_acc) begin
        px_r <= px_in;
        py_r <= py_in;
      end
      if (acc_en) begin
        e_acc[acc_k[2:1]] <= acc_k[0]
          ? e_acc[acc_k[2:1]] - EW'(prod)
          : EW'(prod);
      end
      if (state == SCALE && cnt != 3'd0) begin
        lam_t[cnt[1]] <= sat_v;
        nn_t[cnt[1]]  <= nn;
        np_t[cnt[1]]  <= np;
      end
      if (state == OUT) begin
        valid_out  <= 1'b1;
        lambda_out <= degen ? '0 : {sat_v, lam_t[1], lam_t[0]};
        inside_out <= ~degen & ((&nn_t & nn) | (&np_t & np));
      end
    end
  end

endmodule

// File: tb/tb_bary_normalize.sv
// Bench for bary_normalize: geometric reference model,
// per-cycle compare process, directed vectors.
module tb_bary_normalize;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        setup_valid_in = 1'b0;
  logic        setup_done_in = 1'b0;
  logic [47:0] vx_in = '0;
  logic [47:0] vy_in = '0;
  logic [28:0] iarea_in = '0;
  logic        pix_valid_in = 1'b0;
  logic        pix_ready_out;
  logic [15:0] px_in = '0;
  logic [15:0] py_in = '0;
  logic        valid_out;
  logic [47:0] lambda_out;
  logic        inside_out;

  bary_normalize dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .setup_valid_in (setup_valid_in),
    .setup_done_in  (setup_done_in),
    .vx_in          (vx_in),
    .vy_in          (vy_in),
    .iarea_in       (iarea_in),
    .pix_valid_in   (pix_valid_in),
    .pix_ready_out  (pix_ready_out),
    .px_in          (px_in),
    .py_in          (py_in),
    .valid_out      (valid_out),
    .lambda_out     (lambda_out),
    .inside_out     (inside_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int     due;
    longint l0, l1, l2;
    bit     ins;
  } exp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int res_cnt = 0;
  int last_acc = 0;
  int prev_acc = 0;
  longint last_l [3];
  bit last_ins;

  longint mvx [3];
  longint mvy [3];
  longint mia = 0;
  bit     mdeg = 1'b1;
  exp_t   q [$];

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", n, act, exp);
    end
  endtask

  function automatic longint lam(input int i);
    return longint'($signed(lambda_out[i*16 +: 16]));
  endfunction

  function automatic longint edgef(input longint ax, ay, bx, by,
                                   input longint px, py);
    return (ax - px) * (by - py) - (bx - px) * (ay - py);
  endfunction

  function automatic longint clamp(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic exp_t calc(input longint px, py);
    exp_t r;
    longint e [3];
    longint s [3];
    bit pos, neg;
    e[0] = edgef(mvx[1], mvy[1], mvx[2], mvy[2], px, py);
    e[1] = edgef(mvx[2], mvy[2], mvx[0], mvy[0], px, py);
    e[2] = edgef(mvx[0], mvy[0], mvx[1], mvy[1], px, py);
    pos = 1'b1;
    neg = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s[i] = (e[i] * mia) >>> 42;
      if (s[i] < 0) pos = 1'b0;
      if (s[i] > 0) neg = 1'b0;
    end
    r.due = 0;
    r.l0  = mdeg ? 0 : clamp(s[0]);
    r.l1  = mdeg ? 0 : clamp(s[1]);
    r.l2  = mdeg ? 0 : clamp(s[2]);
    r.ins = !mdeg && (pos || neg);
    return r;
  endfunction

  always @(negedge clk_in) begin : monitor
    exp_t e;
    if (!rst_n_in) begin
      q.delete();
      mdeg = 1'b1;
      chk("rst_valid", valid_out, 0);
      chk("rst_lambda", lambda_out, 0);
      chk("rst_inside", inside_out, 0);
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("valid_on_time", valid_out, 1);
        chk("lambda0", lam(0), e.l0);
        chk("lambda1", lam(1), e.l1);
        chk("lambda2", lam(2), e.l2);
        chk("inside", inside_out, e.ins);
        for (int i = 0; i < 3; i++) last_l[i] = lam(i);
        last_ins = inside_out;
        res_cnt++;
      end else if (valid_out) begin
        chk("valid_spurious", valid_out, 0);
      end
      chk("pix_ready", pix_ready_out,
          (q.size() == 0 && !setup_done_in) ? 1 : 0);
      if (q.size() == 0 && setup_done_in) begin
        for (int i = 0; i < 3; i++) begin
          mvx[i] = longint'($signed(vx_in[i*16 +: 16]));
          mvy[i] = longint'($signed(vy_in[i*16 +: 16]));
        end
        mia  = longint'(iarea_in);
        mdeg = !setup_valid_in;
      end
      if (pix_valid_in && pix_ready_out) begin
        e = calc(longint'($signed(px_in)), longint'($signed(py_in)));
        e.due = cyc + 11;
        q.push_back(e);
        acc_cnt++;
        prev_acc = last_acc;
        last_acc = cyc;
      end
    end
  end

  task automatic drive_tri(input int x0, x1, x2, y0, y1, y2,
                           input int unsigned ia, input bit v);
    vx_in = {16'(x2), 16'(x1), 16'(x0)};
    vy_in = {16'(y2), 16'(y1), 16'(y0)};
    iarea_in = 29'(ia);
    setup_valid_in = v;
    setup_done_in = 1'b1;
  endtask

  task automatic do_setup(input int x0, x1, x2, y0, y1, y2,
                          input int unsigned ia, input bit v);
    @(posedge clk_in); #1;
    drive_tri(x0, x1, x2, y0, y1, y2, ia, v);
    @(posedge clk_in); #1;
    setup_done_in = 1'b0;
    setup_valid_in = 1'b0;
  endtask

  task automatic timeout(input string n);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", n);
  endtask

  // Pixel already driven valid: wait for accept, then result.
  task automatic finish_pixel(input string n, input int a0, r0,
                              output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_in); #1;
      if (acc_cnt != a0) break;
    end
    pix_valid_in = 1'b0;
    if (acc_cnt == a0) begin
      timeout({n, "_accept"});
      return;
    end
    for (int i = 0; i < 30; i++) begin
      if (res_cnt != r0) break;
      @(posedge clk_in); #1;
    end
    if (res_cnt == r0) timeout({n, "_result"});
    else ok = 1'b1;
  endtask

  task automatic pixel_chk(input string n, input int x, y,
                           input longint l0, l1, l2, input bit ins);
    int a0, r0;
    bit ok;
    @(posedge clk_in); #1;
    a0 = acc_cnt;
    r0 = res_cnt;
    pix_valid_in = 1'b1;
    px_in = 16'(x);
    py_in = 16'(y);
    finish_pixel(n, a0, r0, ok);
    if (ok) begin
      chk({n, "_l0"}, last_l[0], l0);
      chk({n, "_l1"}, last_l[1], l1);
      chk({n, "_l2"}, last_l[2], l2);
      chk({n, "_in"}, last_ins, ins);
    end
  endtask

  initial begin : stim
    int a0, r0;
    bit ok;
    repeat (3) @(posedge clk_in);
    #3 rst_n_in = 1'b1;
    #1 chk("ready_after_reset", pix_ready_out, 1);

    pixel_chk("pre_setup", 4096, 4096, 0, 0, 0, 0);

    do_setup(0, 16384, 0, 0, 0, 16384, 268435456, 1);
    pixel_chk("ccw_in", 4096, 4096, 8192, 4096, 4096, 1);
    pixel_chk("ccw_out", 16384, 16384, -16384, 16384, 16384, 0);
    pixel_chk("ccw_sat", -24576, -24576, 32767, -24576, -24576, 0);
    pixel_chk("ccw_vertex", 0, 0, 16384, 0, 0, 1);

    do_setup(0, 12000, 3000, 0, 2000, 15000, 200000000, 1);
    @(posedge clk_in); #1;
    a0 = acc_cnt;
    r0 = res_cnt;
    pix_valid_in = 1'b1;
    px_in = 16'(5000);
    py_in = 16'(6000);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_in); #1;
      if (acc_cnt == a0 + 1) px_in = 16'(-700);
      if (acc_cnt >= a0 + 2) break;
    end
    pix_valid_in = 1'b0;
    if (acc_cnt < a0 + 2) timeout("b2b_accept");
    else chk("b2b_spacing", last_acc - prev_acc, 11);
    for (int i = 0; i < 30; i++) begin
      if (res_cnt >= r0 + 2) break;
      @(posedge clk_in); #1;
    end
    if (res_cnt < r0 + 2) timeout("b2b_result");

    @(posedge clk_in); #1;
    drive_tri(0, 0, 16384, 0, 16384, 0, 268435456, 1);
    pix_valid_in = 1'b1;
    px_in = 16'(4096);
    py_in = 16'(4096);
    a0 = acc_cnt;
    r0 = res_cnt;
    #3 chk("ready_during_setup", pix_ready_out, 0);
    @(posedge clk_in); #1;
    setup_done_in = 1'b0;
    setup_valid_in = 1'b0;
    chk("no_accept_with_setup", acc_cnt, a0);
    finish_pixel("cw", a0, r0, ok);
    if (ok) begin
      chk("cw_l0", last_l[0], -8192);
      chk("cw_l1", last_l[1], -4096);
      chk("cw_l2", last_l[2], -4096);
      chk("cw_in", last_ins, 1);
    end

    do_setup(0, 16384, 0, 0, 0, 16384, 268435456, 1);
    @(posedge clk_in); #1;
    a0 = acc_cnt;
    pix_valid_in = 1'b1;
    px_in = 16'(4096);
    py_in = 16'(4096);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_in); #1;
      if (acc_cnt != a0) break;
    end
    pix_valid_in = 1'b0;
    if (acc_cnt == a0) timeout("rst_accept");
    repeat (3) @(posedge clk_in);
    #1 rst_n_in = 1'b0;
    #1 chk("midrst_valid", valid_out, 0);
    chk("midrst_lambda", lambda_out, 0);
    @(negedge clk_in);
    @(posedge clk_in); #3;
    rst_n_in = 1'b1;
    repeat (15) @(posedge clk_in);
    chk("midrst_no_result", res_cnt, r0 + 1);
    pixel_chk("post_rst", 4096, 4096, 0, 0, 0, 0);

    do_setup(0, 16384, 0, 0, 0, 16384, 268435456, 0);
    pixel_chk("degen", 4096, 4096, 0, 0, 0, 0);

    repeat (3) @(posedge clk_in);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bary_normalize.md
Name: bary_normalize

Overview:
- Consumer end of the inverse-area interface in the rasterizer.
- Latches a triangle's vertices together with the iarea result (1/(2·area), FRAC·2 fractional bits), then accepts pixel queries.
- For each pixel, computes the three edge functions and scales them by iarea to produce normalized barycentric weights and an inside flag.
- Uses one shared registered multiplier, so each pixel is processed over multiple cycles.

Parameters:
- XWIDTH, 16, signed vertex/pixel x width, FRAC fractional bits
- YWIDTH, 16, signed vertex/pixel y width, FRAC fractional bits
- FRAC, 14, fractional bits of coordinates and output weights
- LWIDTH, 16, signed output weight width (FRAC fractional bits)
- INV_WIDTH, 29, iarea width (2·FRAC fractional bits, unsigned); computed by the package function from XWIDTH/YWIDTH/FRAC

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  asynchronous active-low reset
- setup_valid_in  in  1  iarea producer's valid_out
- setup_done_in  in  1  iarea producer's done; done=1 with valid=0 means degenerate (zero-area) triangle
- vx_in  in  3×XWIDTH  vertex x, packed [2:0]
- vy_in  in  3×YWIDTH  vertex y, packed [2:0]
- iarea_in  in  INV_WIDTH  inverse area
- pix_valid_in  in  1  pixel query valid
- pix_ready_out  out  1  pixel query accepted when valid&ready
- px_in  in  XWIDTH  pixel x
- py_in  in  YWIDTH  pixel y
- valid_out  out  1  one-cycle result strobe
- lambda_out  out  3×LWIDTH  signed weights [2:0]
- inside_out  out  1  pixel inside or on triangle

Behaviour:
- Reset (asynchronous, any time, including mid-pixel):
  - valid_out=0, lambda_out=0, inside_out=0.
  - State=IDLE; degenerate flag=1, so a pixel arriving before any setup reports outside.
  - Any in-flight pixel is discarded.
- Setup:
  - Sampled only in IDLE when setup_done_in=1.
  - Latches vx, vy and iarea; degenerate flag <= ~setup_valid_in.
  - Setup has priority: pix_ready_out = (state==IDLE) & ~setup_done_in. This is combinational, and a pixel is never consumed in the same cycle as a setup.
  - setup_done_in while busy is ignored; the producer must hold it or re-issue it.
- State machine:
  - IDLE → MUL on pixel accept.
  - MUL: 6 cycles; edge products k=0..5.
    - e0 = (x1−px)(y2−py) − (x2−px)(y1−py)
    - e1 = (x2−px)(y0−py) − (x0−px)(y2−py)
    - e2 = (x0−px)(y1−py) − (x1−px)(y0−py)
  - SCALE: 3 cycles; ei·iarea.
  - OUT: 1 cycle; valid_out=1, then → IDLE.
- Latency and throughput:
  - valid_out asserts exactly 10 cycles after the accepting edge and stays high for 1 cycle.
  - pix_ready_out returns high in the cycle after OUT.
  - Throughput is 1 pixel per 11 cycles.
- Arithmetic:
  - Differences are XWIDTH+1 bits; products are full precision (2·FRAC fractional bits).
  - Edge values are accumulated at 2·(XWIDTH+1)+1 bits with no truncation.
  - Scaled product carries 4·FRAC fractional bits. It is arithmetic-shifted right by 3·FRAC (floor), then saturated to [−2^(LWIDTH−1), 2^(LWIDTH−1)−1].
- Winding:
  - iarea is always positive, so clockwise triangles give all-negative weights.
  - inside_out = (all three pre-saturation scaled values ≥0) or (all ≤0), and not degenerate.
- Degenerate triangle: full latency is still observed; lambda_out=0, inside_out=0.
- Outputs lambda_out and inside_out hold their value until the next OUT.

Decomposition:
- rast_pkg holds:
  - the inv_width(XWIDTH,YWIDTH,FRAC) function, which evaluates to 29 for the defaults
  - EDGE_WIDTH and SCALE_WIDTH localparam functions
  - the state enum {IDLE, MUL, SCALE, OUT}
- One sub-module: signed_mul_reg, a registered signed multiplier with operand widths as parameters and 1-cycle latency, shared by the MUL and SCALE phases.

Test Plan:
- CCW triangle: vx={0,16384,0}, vy={0,0,16384}, iarea=268435456, pixel (4096,4096) → 10 cycles later lambda={8192,4096,4096}, inside=1.
- Same triangle, pixel (16384,16384) → lambda={−16384,16384,16384}, inside=0.
- CW triangle: vx={0,0,16384}, vy={0,16384,0}, same iarea, pixel (4096,4096) → lambda={−8192,−4096,−4096}, inside=1.
- Saturation: CCW triangle, pixel (−24576,−24576) → lambda={32767,−24576,−24576}, inside=0.
- Degenerate: setup_done=1 with setup_valid=0, then pixel → valid_out after 10 cycles, lambda=0, inside=0.
- Handshake and reset:
  - setup_done_in and pix_valid_in asserted in the same IDLE cycle → pix_ready_out=0 and the pixel is consumed next cycle under the new setup.
  - Back-to-back pixels are spaced 11 cycles apart.
  - rst_n_in low at MUL cycle 3 → immediate valid_out=0, no result is emitted, and the next pixel reports degenerate.
